// File: rtl/apb_regfile_slave_if.sv
// APB4 bus bundle between an APB requester and the register-file completer.
// The slave modport is the completer view; master is the requester view.
interface apb_regfile_slave_if;
  logic [31:0] apb_addr_i;
  logic        apb_sel_i;
  logic        apb_enable_i;
  logic        apb_write_i;
  logic [3:0]  apb_strb_i;
  logic [2:0]  apb_prot_i;
  logic [31:0] apb_wdata_i;
  logic        apb_ready_o;
  logic [31:0] apb_rdata_o;
  logic        apb_slverr_o;

  modport slave (
    input  apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
    input  apb_strb_i, apb_prot_i, apb_wdata_i,
    output apb_ready_o, apb_rdata_o, apb_slverr_o
  );

  modport master (
    output apb_addr_i, apb_sel_i, apb_enable_i, apb_write_i,
    output apb_strb_i, apb_prot_i, apb_wdata_i,
    input  apb_ready_o, apb_rdata_o, apb_slverr_o
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// APB4 completer with NUM_REGS byte-strobed 32-bit registers and fixed wait states.
// Optional protection checking is enabled by defining APB_REGFILE_PROT_CHECK_EN.
module apb_regfile_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                     apb_clk_i,
  input  logic                     apb_resetn_i,
  apb_regfile_slave_if.slave       apb,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 ready_q, ready_n;
  logic [31:0]          rdata_q, rdata_n;
  logic                 slverr_q, slverr_n;
  logic [NUM_REGS-1:0]  pulse_q, pulse_n;
  logic [31:0]          regs [NUM_REGS];

  logic [31:0]          off;
  logic [29:0]          idx;
  logic [IDX_W-1:0]     idx_s;
  logic                 dec_err;
  logic                 prot_err;
  logic                 acc_err;
  logic [31:0]          rd_word;
  logic [31:0]          resp_rdata;
  logic                 wr_en;
  logic                 sig_unused;

  // Address decode relative to BASE_ADDR
  assign off     = apb.apb_addr_i - BASE_ADDR;
  assign idx     = off[31:2];
  assign idx_s   = idx[IDX_W-1:0];
  assign dec_err = (apb.apb_addr_i < BASE_ADDR) ||
                   (idx >= 30'(NUM_REGS)) ||
                   (apb.apb_addr_i[1:0] != 2'b00);

`ifdef APB_REGFILE_PROT_CHECK_EN
  // Unprivileged accesses fail anywhere; non-secure accesses fail on register 0
  assign prot_err   = !apb.apb_prot_i[0] || (apb.apb_prot_i[1] && (idx == 30'd0));
  assign sig_unused = ^{off[1:0], apb.apb_prot_i[2]};
`else
  assign prot_err   = 1'b0;
  assign sig_unused = ^{off[1:0], apb.apb_prot_i};
`endif

  assign acc_err    = dec_err || prot_err;
  assign rd_word    = dec_err ? 32'h0 : regs[idx_s];
  assign resp_rdata = (acc_err || apb.apb_write_i) ? 32'h0 : rd_word;

  // Next-state and response logic
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ready_n  = ready_q;
    rdata_n  = rdata_q;
    slverr_n = slverr_q;
    pulse_n  = '0;
    wr_en    = 1'b0;

    case (state)
      IDLE: begin
        ready_n  = 1'b0;
        rdata_n  = 32'h0;
        slverr_n = 1'b0;
        cnt_n    = '0;
        if (apb.apb_sel_i) begin
          state_n = ACCESS;
          cnt_n   = CNT_W'(WAIT_STATES);
          ready_n = (WAIT_STATES == 0);
          if (WAIT_STATES == 0) begin
            rdata_n  = resp_rdata;
            slverr_n = acc_err;
          end
        end
      end

      ACCESS: begin
        if (!apb.apb_sel_i) begin
          state_n  = IDLE;
          cnt_n    = '0;
          ready_n  = 1'b0;
          rdata_n  = 32'h0;
          slverr_n = 1'b0;
        end else if (!ready_q) begin
          cnt_n   = cnt - CNT_W'(1);
          ready_n = (cnt == CNT_W'(1));
          if (cnt == CNT_W'(1)) begin
            rdata_n  = resp_rdata;
            slverr_n = acc_err;
          end
        end else if (apb.apb_enable_i) begin
          state_n  = IDLE;
          cnt_n    = '0;
          ready_n  = 1'b0;
          rdata_n  = 32'h0;
          slverr_n = 1'b0;
          if (apb.apb_write_i && !acc_err) begin
            wr_en          = 1'b1;
            pulse_n[idx_s] = 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      state    <= IDLE;
      cnt      <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      slverr_q <= 1'b0;
      pulse_q  <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ready_q  <= ready_n;
      rdata_q  <= rdata_n;
      slverr_q <= slverr_n;
      pulse_q  <= pulse_n;
    end
  end

  // Register bank with byte-strobe writes
  always_ff @(posedge apb_clk_i or negedge apb_resetn_i) begin
    if (!apb_resetn_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (apb.apb_strb_i[b]) begin
          regs[idx_s][8*b +: 8] <= apb.apb_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[32*i +: 32] = regs[i];
    end
  end

  assign apb.apb_ready_o  = ready_q;
  assign apb.apb_rdata_o  = rdata_q;
  assign apb.apb_slverr_o = slverr_q;
  assign wr_pulse_o       = pulse_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: three completers (0, 3 and 2 wait states) on a shared APB driver,
// with per-target select gating. Prot cases follow APB_REGFILE_PROT_CHECK_EN.
module tb_apb_regfile_slave;

  logic        clk;
  logic        rst_n;
  int          tgt;
  logic        sel;
  logic        enable;
  logic        write;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [255:0] regs0, regs3, regs2;
  logic [7:0]   pulse0, pulse3, pulse2;
  logic [255:0] exp0, exp3, exp2;

  int errors = 0;
  int checks = 0;

  apb_regfile_slave_if if0 ();
  apb_regfile_slave_if if3 ();
  apb_regfile_slave_if if2 ();

  assign if0.apb_sel_i = sel && (tgt == 0);
  assign if3.apb_sel_i = sel && (tgt == 3);
  assign if2.apb_sel_i = sel && (tgt == 2);
  assign if0.apb_enable_i = enable;
  assign if3.apb_enable_i = enable;
  assign if2.apb_enable_i = enable;
  assign if0.apb_write_i = write;
  assign if3.apb_write_i = write;
  assign if2.apb_write_i = write;
  assign if0.apb_addr_i = addr;
  assign if3.apb_addr_i = addr;
  assign if2.apb_addr_i = addr;
  assign if0.apb_wdata_i = wdata;
  assign if3.apb_wdata_i = wdata;
  assign if2.apb_wdata_i = wdata;
  assign if0.apb_strb_i = strb;
  assign if3.apb_strb_i = strb;
  assign if2.apb_strb_i = strb;
  assign if0.apb_prot_i = prot;
  assign if3.apb_prot_i = prot;
  assign if2.apb_prot_i = prot;

  apb_regfile_slave #(.BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_STATES(0),
                      .RESET_VAL(32'h0000_0000)) u0 (
    .apb_clk_i(clk), .apb_resetn_i(rst_n), .apb(if0.slave),
    .regs_o(regs0), .wr_pulse_o(pulse0));

  apb_regfile_slave #(.BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_STATES(3),
                      .RESET_VAL(32'hA5A5_0003)) u3 (
    .apb_clk_i(clk), .apb_resetn_i(rst_n), .apb(if3.slave),
    .regs_o(regs3), .wr_pulse_o(pulse3));

  apb_regfile_slave #(.BASE_ADDR(32'h0000_1000), .NUM_REGS(8), .WAIT_STATES(2),
                      .RESET_VAL(32'h5A5A_0002)) u2 (
    .apb_clk_i(clk), .apb_resetn_i(rst_n), .apb(if2.slave),
    .regs_o(regs2), .wr_pulse_o(pulse2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic get_ready(input int k);
    case (k)
      0: return if0.apb_ready_o;
      3: return if3.apb_ready_o;
      default: return if2.apb_ready_o;
    endcase
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    case (k)
      0: return if0.apb_rdata_o;
      3: return if3.apb_rdata_o;
      default: return if2.apb_rdata_o;
    endcase
  endfunction

  function automatic logic get_slverr(input int k);
    case (k)
      0: return if0.apb_slverr_o;
      3: return if3.apb_slverr_o;
      default: return if2.apb_slverr_o;
    endcase
  endfunction

  function automatic logic [7:0] get_pulse(input int k);
    case (k)
      0: return pulse0;
      3: return pulse3;
      default: return pulse2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transfer: setup, access with bounded wait, then one idle cycle.
  task automatic xfer(input int k, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic err, output int waits,
                      output logic [7:0] p_now, output logic [7:0] p_next,
                      output logic rdy_after);
    tgt = k; write = w; addr = a; wdata = d; strb = s;
    sel = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    waits = 0;
    while (!get_ready(k) && waits < 40) begin
      waits++;
      @(posedge clk); #1;
    end
    rd  = get_rdata(k);
    err = get_slverr(k);
    @(posedge clk); #1;
    p_now     = get_pulse(k);
    rdy_after = get_ready(k);
    sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    p_next = get_pulse(k);
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  logic [7:0]  pn, pnx;
  logic        ra;

  initial begin
    rst_n = 1'b0; tgt = 0; sel = 1'b0; enable = 1'b0; write = 1'b0;
    strb = 4'h0; prot = 3'b001; addr = 32'h0; wdata = 32'h0;
    exp0 = '0;
    exp3 = {8{32'hA5A5_0003}};
    exp2 = {8{32'h5A5A_0002}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 256'(if0.apb_ready_o), 256'(1'b0));
    check("rst_rdata", 256'(if0.apb_rdata_o), 256'(32'h0));
    check("rst_slverr", 256'(if0.apb_slverr_o), 256'(1'b0));
    check("rst_pulse", 256'(pulse0), 256'(8'h00));
    check("rst_regs0", regs0, exp0);
    check("rst_regs3", regs3, exp3);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write and readback, zero wait states
    xfer(0, 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, rd, err, waits, pn, pnx, ra);
    check("w1_waits", 256'(waits), 256'(0));
    check("w1_slverr", 256'(err), 256'(1'b0));
    check("w1_pulse", 256'(pn), 256'(8'h02));
    check("w1_pulse_next", 256'(pnx), 256'(8'h00));
    check("w1_ready_after", 256'(ra), 256'(1'b0));
    check("w1_reg1", 256'(regs0[63:32]), 256'(32'hDEAD_BEEF));
    exp0[63:32] = 32'hDEAD_BEEF;
    xfer(0, 1'b0, 32'h0000_1004, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("r1_waits", 256'(waits), 256'(0));
    check("r1_rdata", 256'(rd), 256'(32'hDEAD_BEEF));
    check("r1_slverr", 256'(err), 256'(1'b0));
    check("r1_no_pulse", 256'(pn), 256'(8'h00));
    check("r1_rdata_after", 256'(get_rdata(0)), 256'(32'h0));

    // Byte-strobe merge
    xfer(0, 1'b1, 32'h0000_1008, 32'h1122_3344, 4'hF, rd, err, waits, pn, pnx, ra);
    xfer(0, 1'b1, 32'h0000_1008, 32'hAABB_CCDD, 4'b0101, rd, err, waits, pn, pnx, ra);
    check("strb_pulse", 256'(pn), 256'(8'h04));
    xfer(0, 1'b0, 32'h0000_1008, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("strb_rdata", 256'(rd), 256'(32'h11BB_33DD));
    exp0[95:64] = 32'h11BB_33DD;
    check("strb_regs0", regs0, exp0);

    // Three wait states on a read
    xfer(3, 1'b0, 32'h0000_1000, 32'h0, 4'hF, rd, err, waits, pn, pnx, ra);
    check("ws3_waits", 256'(waits), 256'(3));
    check("ws3_rdata", 256'(rd), 256'(32'hA5A5_0003));
    check("ws3_slverr", 256'(err), 256'(1'b0));
    check("ws3_ready_after", 256'(ra), 256'(1'b0));

    // Decode errors
    xfer(0, 1'b1, 32'h0000_1020, 32'hFFFF_FFFF, 4'hF, rd, err, waits, pn, pnx, ra);
    check("oob_slverr", 256'(err), 256'(1'b1));
    check("oob_rdata", 256'(rd), 256'(32'h0));
    check("oob_pulse", 256'(pn), 256'(8'h00));
    check("oob_regs0", regs0, exp0);
    xfer(0, 1'b0, 32'h0000_1002, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("unal_slverr", 256'(err), 256'(1'b1));
    check("unal_rdata", 256'(rd), 256'(32'h0));
    xfer(0, 1'b0, 32'h0000_0FFC, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("below_slverr", 256'(err), 256'(1'b1));
    xfer(0, 1'b0, 32'h0000_101C, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("last_slverr", 256'(err), 256'(1'b0));
    check("last_rdata", 256'(rd), 256'(32'h0));

    // Zero-strobe write still pulses, register unchanged
    xfer(0, 1'b1, 32'h0000_100C, 32'hFFFF_FFFF, 4'h0, rd, err, waits, pn, pnx, ra);
    check("strb0_pulse", 256'(pn), 256'(8'h08));
    check("strb0_regs0", regs0, exp0);

    // Abort after one access cycle with two wait states
    tgt = 2; write = 1'b1; addr = 32'h0000_1004; wdata = 32'h1234_5678; strb = 4'hF;
    sel = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    check("abort_wait_ready", 256'(get_ready(2)), 256'(1'b0));
    @(posedge clk); #1;
    sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 256'(get_ready(2)), 256'(1'b0));
    check("abort_rdata", 256'(get_rdata(2)), 256'(32'h0));
    check("abort_slverr", 256'(get_slverr(2)), 256'(1'b0));
    check("abort_pulse", 256'(pulse2), 256'(8'h00));
    check("abort_regs2", regs2, exp2);
    xfer(2, 1'b1, 32'h0000_1004, 32'h1234_5678, 4'hF, rd, err, waits, pn, pnx, ra);
    check("post_abort_waits", 256'(waits), 256'(2));
    check("post_abort_pulse", 256'(pn), 256'(8'h02));
    exp2[63:32] = 32'h1234_5678;
    check("post_abort_regs2", regs2, exp2);

    // Reset during wait states
    tgt = 2; write = 1'b1; addr = 32'h0000_1014; wdata = 32'hCAFE_F00D; strb = 4'hF;
    sel = 1'b1; enable = 1'b0;
    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    exp0 = '0;
    exp2 = {8{32'h5A5A_0002}};
    check("midrst_ready", 256'(get_ready(2)), 256'(1'b0));
    check("midrst_regs2", regs2, exp2);
    check("midrst_regs0", regs0, exp0);
    sel = 1'b0; enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_pulse", 256'(pulse2), 256'(8'h00));
    xfer(2, 1'b1, 32'h0000_1014, 32'hCAFE_F00D, 4'hF, rd, err, waits, pn, pnx, ra);
    check("post_rst_waits", 256'(waits), 256'(2));
    check("post_rst_pulse", 256'(pn), 256'(8'h20));
    exp2[191:160] = 32'hCAFE_F00D;
    check("post_rst_regs2", regs2, exp2);

    // Protection attributes
    prot = 3'b000;
    xfer(0, 1'b1, 32'h0000_1004, 32'h0BAD_F00D, 4'hF, rd, err, waits, pn, pnx, ra);
`ifdef APB_REGFILE_PROT_CHECK_EN
    check("prot0_slverr", 256'(err), 256'(1'b1));
    check("prot0_pulse", 256'(pn), 256'(8'h00));
    check("prot0_regs0", regs0, exp0);
    prot = 3'b001;
    xfer(0, 1'b1, 32'h0000_1004, 32'h0BAD_F00D, 4'hF, rd, err, waits, pn, pnx, ra);
    check("prot1_slverr", 256'(err), 256'(1'b0));
    check("prot1_pulse", 256'(pn), 256'(8'h02));
    exp0[63:32] = 32'h0BAD_F00D;
    check("prot1_regs0", regs0, exp0);
    prot = 3'b011;
    xfer(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, rd, err, waits, pn, pnx, ra);
    check("prot_ns_idx0_slverr", 256'(err), 256'(1'b1));
`else
    check("prot_ign_slverr", 256'(err), 256'(1'b0));
    check("prot_ign_pulse", 256'(pn), 256'(8'h02));
    exp0[63:32] = 32'h0BAD_F00D;
    check("prot_ign_regs0", regs0, exp0);
`endif
    prot = 3'b001;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
